// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-to-UART drain stage.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: tick marks the last clock of each serial bit.
module uart_baud_gen
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO and serialises them: start, 8 data LSB first,
// optional even parity, one stop bit.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       txEnable,
  input  logic       empty,
  output logic       read,
  input  logic [7:0] fifoData,
  output logic       txd,
  output logic       busy,
  output logic       frameDone
);

  localparam int unsigned IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  state_t                 state;
  logic [DATA_BITS-1:0]   shift;
  logic [IW-1:0]          bitIdx;
  logic                   parity;
  logic                   tick;
  logic                   clear;

  // Holding the counter clear through IDLE/FETCH/LOAD zeroes it on START entry;
  // every later state change coincides with a tick, where it wraps to zero anyway.
  assign clear = (state == IDLE) || (state == FETCH) || (state == LOAD);

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) baud (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .tick  (tick)
  );

  assign read      = (state == FETCH);
  assign busy      = (state != IDLE);
  assign frameDone = (state == STOP) && tick;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      txd    <= LINE_IDLE;
      shift  <= '0;
      bitIdx <= '0;
      parity <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          txd <= LINE_IDLE;
          if (txEnable && !empty) state <= FETCH;
        end
        FETCH: state <= LOAD;
        LOAD: begin
          shift  <= fifoData;
          parity <= ^fifoData;
          bitIdx <= '0;
          txd    <= 1'b0;
          state  <= START;
        end
        START: begin
          if (tick) begin
            txd   <= shift[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shift <= shift >> 1;
            if (bitIdx == LAST_BIT) begin
              txd   <= PARITY_EN ? parity : LINE_IDLE;
              state <= PARITY_EN ? PARITY : STOP;
            end else begin
              txd    <= shift[1];
              bitIdx <= bitIdx + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            txd   <= LINE_IDLE;
            state <= STOP;
          end
        end
        STOP: begin
          if (tick) state <= IDLE;
        end
        default: begin
          txd   <= LINE_IDLE;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one instance without parity, one with.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic       te0, em0, rd0, txd0, busy0, fd0;
  logic [7:0] dat0;
  logic       te1, em1, rd1, txd1, busy1, fd1;
  logic [7:0] dat1;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  int checks   = 0;
  int failures = 0;
  int reads0   = 0;
  int reads1   = 0;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut (
    .clock     (clock),
    .reset     (reset),
    .txEnable  (te0),
    .empty     (em0),
    .read      (rd0),
    .fifoData  (dat0),
    .txd       (txd0),
    .busy      (busy0),
    .frameDone (fd0)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dutp (
    .clock     (clock),
    .reset     (reset),
    .txEnable  (te1),
    .empty     (em1),
    .read      (rd1),
    .fifoData  (dat1),
    .txd       (txd1),
    .busy      (busy1),
    .frameDone (fd1)
  );

  // FIFO models: a read seen in cycle N+1 presents data for the LOAD cycle.
  always @(negedge clock) begin
    if (rd0) begin
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL underflow0: read with empty FIFO, got read=1 want no read");
      end else begin
        dat0 = q0.pop_front();
      end
      reads0++;
    end
    em0 = (q0.size() == 0);
  end

  always @(negedge clock) begin
    if (rd1) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL underflow1: read with empty FIFO, got read=1 want no read");
      end else begin
        dat1 = q1.pop_front();
      end
      reads1++;
    end
    em1 = (q1.size() == 0);
  end

  function automatic logic txd_of(input int w);
    return (w == 1) ? txd1 : txd0;
  endfunction

  function automatic logic fd_of(input int w);
    return (w == 1) ? fd1 : fd0;
  endfunction

  task automatic push0(input logic [7:0] b);
    q0.push_back(b);
    em0 = 1'b0;
  endtask

  task automatic push1(input logic [7:0] b);
    q1.push_back(b);
    em1 = 1'b0;
  endtask

  // Waits (bounded) for the start bit, then checks every cycle of the frame.
  // exp bit s is the line level expected in bit slot s. Ends on the last stop cycle.
  task automatic check_frame(input int w, input string name, input int nbits,
                             input logic [10:0] exp);
    int guard = 0;
    logic efd;
    while (txd_of(w) !== 1'b0 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    checks++;
    if (guard >= 200) begin
      failures++;
      $display("FAIL %s_start: no start bit seen, got txd=%b want 0", name, txd_of(w));
      return;
    end
    for (int s = 0; s < nbits; s++) begin
      for (int c = 0; c < CPB; c++) begin
        if (s != 0 || c != 0) @(negedge clock);
        checks++;
        if (txd_of(w) !== exp[s]) begin
          failures++;
          $display("FAIL %s_txd slot %0d cyc %0d: got %b want %b", name, s, c, txd_of(w), exp[s]);
        end
        efd = (s == nbits - 1) && (c == CPB - 1);
        checks++;
        if (fd_of(w) !== efd) begin
          failures++;
          $display("FAIL %s_frameDone slot %0d cyc %0d: got %b want %b", name, s, c, fd_of(w), efd);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({txd0, rd0, busy0, fd0} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_outputs: got txd/read/busy/fd=%b want 1000", {txd0, rd0, busy0, fd0});
    end
    reset = 1'b0;
    te0 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      checks++;
      if ({txd0, rd0, busy0} !== 3'b100) begin
        failures++;
        $display("FAIL idle_empty cyc %0d: got txd/read/busy=%b want 100", i, {txd0, rd0, busy0});
      end
    end
  endtask

  task automatic test_single();
    int r;
    @(negedge clock);
    r = reads0;
    push0(8'hA5);
    @(negedge clock);
    checks++;
    if ({rd0, busy0} !== 2'b11) begin
      failures++;
      $display("FAIL latency_read: got read/busy=%b want 11", {rd0, busy0});
    end
    @(negedge clock);
    checks++;
    if ({rd0, txd0} !== 2'b01) begin
      failures++;
      $display("FAIL latency_load: got read/txd=%b want 01", {rd0, txd0});
    end
    @(negedge clock);
    checks++;
    if (txd0 !== 1'b0) begin
      failures++;
      $display("FAIL latency_start: got txd=%b want 0", txd0);
    end
    check_frame(0, "a5", 10, {1'b0, 1'b1, 8'hA5, 1'b0});
    @(negedge clock);
    checks++;
    if ({busy0, txd0} !== 2'b01) begin
      failures++;
      $display("FAIL a5_after: got busy/txd=%b want 01", {busy0, txd0});
    end
    checks++;
    if (reads0 - r !== 1) begin
      failures++;
      $display("FAIL a5_reads: got %0d want 1", reads0 - r);
    end
  endtask

  task automatic test_parity();
    te1 = 1'b1;
    @(negedge clock);
    push1(8'hA5);
    check_frame(1, "par_a5", 11, {1'b1, 1'b0, 8'hA5, 1'b0});
    @(negedge clock);
    push1(8'h07);
    check_frame(1, "par_07", 11, {1'b1, 1'b1, 8'h07, 1'b0});
    @(negedge clock);
    checks++;
    if (reads1 !== 2) begin
      failures++;
      $display("FAIL par_reads: got %0d want 2", reads1);
    end
  endtask

  task automatic test_back_to_back();
    int r;
    int n;
    @(negedge clock);
    r = reads0;
    push0(8'h00);
    push0(8'hFF);
    check_frame(0, "b2b_00", 10, {1'b0, 1'b1, 8'h00, 1'b0});
    n = 0;
    @(negedge clock);
    while (txd0 === 1'b1 && n < 20) begin
      n++;
      @(negedge clock);
    end
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL b2b_gap: got %0d high cycles want 3", n);
    end
    check_frame(0, "b2b_ff", 10, {1'b0, 1'b1, 8'hFF, 1'b0});
    checks++;
    if (reads0 - r !== 2) begin
      failures++;
      $display("FAIL b2b_reads: got %0d want 2", reads0 - r);
    end
  endtask

  task automatic test_reset_mid();
    int r;
    int guard = 0;
    @(negedge clock);
    push0(8'h3C);
    while (txd0 !== 1'b0 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    // 4 start cycles + bits 0..2, then one cycle into bit 3 (a '1' for 8'h3C)
    repeat (4 * CPB + 1) @(negedge clock);
    checks++;
    if ({busy0, txd0} !== 2'b11) begin
      failures++;
      $display("FAIL mid_bit3: got busy/txd=%b want 11", {busy0, txd0});
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({txd0, busy0, rd0, fd0} !== 4'b1000) begin
      failures++;
      $display("FAIL mid_async: got txd/busy/read/fd=%b want 1000", {txd0, busy0, rd0, fd0});
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    r = reads0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      checks++;
      if ({txd0, busy0} !== 2'b10) begin
        failures++;
        $display("FAIL mid_idle cyc %0d: got txd/busy=%b want 10", i, {txd0, busy0});
      end
    end
    checks++;
    if (reads0 !== r) begin
      failures++;
      $display("FAIL mid_noread: got %0d reads want 0", reads0 - r);
    end
    push0(8'h81);
    check_frame(0, "mid_81", 10, {1'b0, 1'b1, 8'h81, 1'b0});
  endtask

  task automatic test_txenable_drop();
    int r;
    int guard = 0;
    @(negedge clock);
    push0(8'h55);
    while (txd0 !== 1'b0 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    te0 = 1'b0;
    push0(8'h12);
    check_frame(0, "drop_55", 10, {1'b0, 1'b1, 8'h55, 1'b0});
    r = reads0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      checks++;
      if ({rd0, busy0, txd0} !== 3'b001) begin
        failures++;
        $display("FAIL drop_hold cyc %0d: got read/busy/txd=%b want 001", i, {rd0, busy0, txd0});
      end
    end
    checks++;
    if (reads0 !== r) begin
      failures++;
      $display("FAIL drop_noread: got %0d reads want 0", reads0 - r);
    end
    te0 = 1'b1;
    check_frame(0, "drop_12", 10, {1'b0, 1'b1, 8'h12, 1'b0});
  endtask

  initial begin
    reset = 1'b1;
    te0 = 1'b0;
    em0 = 1'b1;
    dat0 = '0;
    te1 = 1'b0;
    em1 = 1'b1;
    dat1 = '0;
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    test_txenable_drop();
    repeat (5) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
